// File: rtl/bus_endpoint_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_endpoint_fifo_if
// Description : Bus-side and device-side signal bundle of one bus endpoint.
// Revision    : 1.0
// ============================================================================
interface bus_endpoint_fifo_if #(
    parameter int pckg_sz = 16
);
    // Bus side
    logic               pndng;
    logic               pop;
    logic [pckg_sz-1:0] D_pop;
    logic               push;
    logic [pckg_sz-1:0] D_push;
    // Device side
    logic               tx_valid;
    logic [pckg_sz-1:0] tx_data;
    logic               tx_ready;
    logic               rx_valid;
    logic [pckg_sz-1:0] rx_data;
    logic               rx_ready;
    // Status
    logic [15:0]        rx_drop_cnt;
    logic [15:0]        rx_miss_cnt;
    logic               underflow;

    // Endpoint view
    modport slave (
        input  pop, push, D_push, tx_valid, tx_data, rx_ready,
        output pndng, D_pop, tx_ready, rx_valid, rx_data,
               rx_drop_cnt, rx_miss_cnt, underflow
    );

    // Bus + device view
    modport master (
        output pop, push, D_push, tx_valid, tx_data, rx_ready,
        input  pndng, D_pop, tx_ready, rx_valid, rx_data,
               rx_drop_cnt, rx_miss_cnt, underflow
    );
endinterface
`default_nettype wire

// File: rtl/bus_endpoint_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bus_endpoint_fifo
// Description : Bus endpoint with device->bus transmit queue and address-
//               filtered bus->device receive queue.
// Revision    : 1.0
// ============================================================================
module bus_endpoint_fifo #(
    parameter int         bits      = 1,
    parameter int         pckg_sz   = 16,
    parameter int         depth     = 8,
    parameter logic [7:0] id        = 8'd0,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  wire logic            clk,
    input  wire logic            reset,
    bus_endpoint_fifo_if.slave   bus
);

    localparam int                c_aw       = $clog2(depth);
    localparam int                c_cw       = c_aw + 1;
    localparam logic [c_cw-1:0]   c_full     = c_cw'(depth);
    localparam logic [c_cw-1:0]   c_cnt_zero = '0;
    localparam logic [c_cw-1:0]   c_cnt_one  = c_cw'(1);
    localparam logic [c_aw-1:0]   c_ptr_one  = c_aw'(1);
    localparam logic [15:0]       c_sat      = 16'hFFFF;

    // ------------------------------------------------------------------
    // Transmit queue (device -> bus)
    // ------------------------------------------------------------------
    logic [pckg_sz-1:0] r_tx_mem [depth];
    logic [c_aw-1:0]    r_tx_wr_ptr;
    logic [c_aw-1:0]    r_tx_rd_ptr;
    logic [c_cw-1:0]    r_tx_cnt;
    logic               w_tx_full;
    logic               w_tx_nempty;
    logic               w_tx_wr;
    logic               w_tx_rd;

    assign w_tx_full   = (r_tx_cnt == c_full);
    assign w_tx_nempty = (r_tx_cnt != c_cnt_zero);
    // A full queue refuses the write even when a pop frees a slot this cycle.
    assign w_tx_wr     = bus.tx_valid & ~w_tx_full;
    assign w_tx_rd     = bus.pop & w_tx_nempty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_cnt    <= '0;
        end else begin
            if (w_tx_wr) begin
                r_tx_wr_ptr <= r_tx_wr_ptr + c_ptr_one;
            end
            if (w_tx_rd) begin
                r_tx_rd_ptr <= r_tx_rd_ptr + c_ptr_one;
            end
            case ({w_tx_wr, w_tx_rd})
                2'b10:   r_tx_cnt <= r_tx_cnt + c_cnt_one;
                2'b01:   r_tx_cnt <= r_tx_cnt - c_cnt_one;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // Storage needs no reset: reads are gated by the occupancy count.
    always_ff @(posedge clk) begin
        if (w_tx_wr) begin
            r_tx_mem[r_tx_wr_ptr] <= bus.tx_data;
        end
    end

    assign bus.pndng    = w_tx_nempty;
    assign bus.tx_ready = ~w_tx_full;
    assign bus.D_pop    = w_tx_nempty ? r_tx_mem[r_tx_rd_ptr] : '0;

    // ------------------------------------------------------------------
    // Receive queue (bus -> device) with destination filtering
    // ------------------------------------------------------------------
    logic [pckg_sz-1:0] r_rx_mem [depth];
    logic [c_aw-1:0]    r_rx_wr_ptr;
    logic [c_aw-1:0]    r_rx_rd_ptr;
    logic [c_cw-1:0]    r_rx_cnt;
    logic [7:0]         w_dest;
    logic               w_match;
    logic               w_rx_full;
    logic               w_rx_nempty;
    logic               w_rx_wr;
    logic               w_rx_rd;
    logic               w_rx_drop;
    logic               w_rx_miss;

    assign w_dest      = bus.D_push[pckg_sz-1 -: 8];
    assign w_match     = (w_dest == id) || (w_dest == broadcast);
    assign w_rx_full   = (r_rx_cnt == c_full);
    assign w_rx_nempty = (r_rx_cnt != c_cnt_zero);
    // Fullness comes from the registered count; a same-cycle device read
    // does not open a slot for the incoming packet.
    assign w_rx_wr     = bus.push & w_match & ~w_rx_full;
    assign w_rx_drop   = bus.push & w_match &  w_rx_full;
    assign w_rx_miss   = bus.push & ~w_match;
    assign w_rx_rd     = bus.rx_ready & w_rx_nempty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_cnt    <= '0;
        end else begin
            if (w_rx_wr) begin
                r_rx_wr_ptr <= r_rx_wr_ptr + c_ptr_one;
            end
            if (w_rx_rd) begin
                r_rx_rd_ptr <= r_rx_rd_ptr + c_ptr_one;
            end
            case ({w_rx_wr, w_rx_rd})
                2'b10:   r_rx_cnt <= r_rx_cnt + c_cnt_one;
                2'b01:   r_rx_cnt <= r_rx_cnt - c_cnt_one;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_rx_wr) begin
            r_rx_mem[r_rx_wr_ptr] <= bus.D_push;
        end
    end

    assign bus.rx_valid = w_rx_nempty;
    assign bus.rx_data  = w_rx_nempty ? r_rx_mem[r_rx_rd_ptr] : '0;

    // ------------------------------------------------------------------
    // Status: saturating loss counters and sticky underflow
    // ------------------------------------------------------------------
    logic [15:0] r_drop_cnt;
    logic [15:0] r_miss_cnt;
    logic        r_underflow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_cnt  <= '0;
            r_miss_cnt  <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_rx_drop && (r_drop_cnt != c_sat)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (w_rx_miss && (r_miss_cnt != c_sat)) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
            if (bus.pop && !w_tx_nempty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.rx_drop_cnt = r_drop_cnt;
    assign bus.rx_miss_cnt = r_miss_cnt;
    assign bus.underflow   = r_underflow;

    // The bus width setting is carried for compatibility only.
    logic w_unused_cfg;
    assign w_unused_cfg = (bits != 0);

endmodule
`default_nettype wire

// File: tb/tb_bus_endpoint_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_endpoint_fifo
// Description : Self-checking bench for bus_endpoint_fifo (id = 3, depth = 8).
// Revision    : 1.0
// ============================================================================
module tb_bus_endpoint_fifo;

    logic clk;
    logic reset;

    bus_endpoint_fifo_if #(.pckg_sz(16)) bus ();

    bus_endpoint_fifo #(
        .bits      (1),
        .pckg_sz   (16),
        .depth     (8),
        .id        (8'd3),
        .broadcast (8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] tx_q [$];
    logic [15:0] rx_q [$];
    int          m_miss = 0;
    int          m_drop = 0;

    typedef struct {
        logic [15:0] d;
        logic [15:0] exp_miss;
        logic [15:0] exp_drop;
        logic        exp_valid;
    } rx_vec_t;

    rx_vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tx_write(input logic [15:0] d);
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        tx_q.push_back(d);
        tick();
        bus.tx_valid = 1'b0;
    endtask

    task automatic tx_pop();
        logic [15:0] e;
        e = tx_q.pop_front();
        check("D_pop", {16'd0, bus.D_pop}, {16'd0, e});
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
    endtask

    task automatic tx_both(input logic [15:0] d);
        logic [15:0] e;
        e = tx_q.pop_front();
        check("D_pop_both", {16'd0, bus.D_pop}, {16'd0, e});
        tx_q.push_back(d);
        bus.pop      = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        tick();
        bus.pop      = 1'b0;
        bus.tx_valid = 1'b0;
    endtask

    // Model the receive side: fullness judged before any same-cycle read.
    task automatic rx_push(input logic [15:0] d, input logic rd);
        logic m;
        logic full;
        logic [15:0] e;
        m    = (d[15:8] == 8'h03) || (d[15:8] == 8'hFF);
        full = (rx_q.size() == 8);
        if (rd && rx_q.size() > 0) begin
            e = rx_q.pop_front();
            check("rx_data_push", {16'd0, bus.rx_data}, {16'd0, e});
        end
        if (m && !full) rx_q.push_back(d);
        else if (m)     m_drop++;
        else            m_miss++;
        bus.push     = 1'b1;
        bus.D_push   = d;
        bus.rx_ready = rd;
        tick();
        bus.push     = 1'b0;
        bus.rx_ready = 1'b0;
    endtask

    task automatic rx_read();
        logic [15:0] e;
        e = rx_q.pop_front();
        check("rx_data", {16'd0, bus.rx_data}, {16'd0, e});
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int writes;
        tbl[0] = '{16'h03AA, 16'd0, 16'd0, 1'b1};
        tbl[1] = '{16'hFF55, 16'd0, 16'd0, 1'b1};
        tbl[2] = '{16'h0477, 16'd1, 16'd0, 1'b1};
        tbl[3] = '{16'h0012, 16'd2, 16'd0, 1'b1};
        tbl[4] = '{16'h03C3, 16'd2, 16'd0, 1'b1};

        reset        = 1'b1;
        bus.pop      = 1'b0;
        bus.push     = 1'b0;
        bus.D_push   = '0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        bus.rx_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_pndng",     {31'd0, bus.pndng},    32'd0);
        check("rst_D_pop",     {16'd0, bus.D_pop},    32'd0);
        check("rst_tx_ready",  {31'd0, bus.tx_ready}, 32'd1);
        check("rst_rx_valid",  {31'd0, bus.rx_valid}, 32'd0);
        check("rst_rx_data",   {16'd0, bus.rx_data},  32'd0);
        check("rst_drop",      {16'd0, bus.rx_drop_cnt}, 32'd0);
        check("rst_miss",      {16'd0, bus.rx_miss_cnt}, 32'd0);
        check("rst_underflow", {31'd0, bus.underflow},   32'd0);

        // Transmit order
        tx_write(16'h0211);
        check("tx_first_pndng", {31'd0, bus.pndng}, 32'd1);
        check("tx_first_D_pop", {16'd0, bus.D_pop}, 32'h0211);
        tx_write(16'h0222);
        tx_write(16'h0233);
        tx_pop();
        tx_pop();
        tx_pop();
        check("tx_empty_pndng", {31'd0, bus.pndng}, 32'd0);
        check("tx_empty_D_pop", {16'd0, bus.D_pop}, 32'd0);

        // Receive address filter, table-driven
        for (int i = 0; i < 5; i++) begin
            rx_push(tbl[i].d, 1'b0);
            check("tbl_miss",  {16'd0, bus.rx_miss_cnt}, {16'd0, tbl[i].exp_miss});
            check("tbl_drop",  {16'd0, bus.rx_drop_cnt}, {16'd0, tbl[i].exp_drop});
            check("tbl_valid", {31'd0, bus.rx_valid},    {31'd0, tbl[i].exp_valid});
        end
        while (rx_q.size() > 0) rx_read();
        check("rx_drained_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("rx_drained_data",  {16'd0, bus.rx_data},  32'd0);

        // Receive overflow; second extra push coincides with a device read
        for (int i = 0; i < 8; i++) rx_push(16'h0300 + 16'(i), 1'b0);
        rx_push(16'h03E0, 1'b0);
        rx_push(16'h03E1, 1'b1);
        check("rx_drop_cnt", {16'd0, bus.rx_drop_cnt}, 32'd2);
        check("rx_miss_keep", {16'd0, bus.rx_miss_cnt}, 32'(m_miss));
        while (rx_q.size() > 0) rx_read();
        check("rx_after_full_valid", {31'd0, bus.rx_valid}, 32'd0);

        // Transmit full; write refused while pop in same cycle
        for (int i = 0; i < 8; i++) tx_write(16'h0500 + 16'(i));
        check("tx_full_ready", {31'd0, bus.tx_ready}, 32'd0);
        begin
            logic [15:0] e;
            e = tx_q.pop_front();
            check("tx_full_D_pop", {16'd0, bus.D_pop}, {16'd0, e});
            bus.pop      = 1'b1;
            bus.tx_valid = 1'b1;
            bus.tx_data  = 16'hBEEF;
            tick();
            bus.pop      = 1'b0;
            bus.tx_valid = 1'b0;
        end
        check("tx_refused_ready", {31'd0, bus.tx_ready}, 32'd1);
        while (tx_q.size() > 0) tx_pop();
        check("tx_full_drained", {31'd0, bus.pndng}, 32'd0);

        // Pointer wrap with 1-3 entries in flight
        writes = 0;
        for (int it = 0; it < 200 && writes < 20; it++) begin
            if (tx_q.size() <= 1) begin
                tx_write(16'h1000 + 16'(writes)); writes++;
            end else if (tx_q.size() >= 3) begin
                tx_pop();
            end else begin
                case ($urandom_range(2, 0))
                    0: begin tx_write(16'h1000 + 16'(writes)); writes++; end
                    1: tx_pop();
                    default: begin tx_both(16'h1000 + 16'(writes)); writes++; end
                endcase
            end
        end
        check("wrap_writes", 32'(writes), 32'd20);
        while (tx_q.size() > 0) tx_pop();
        check("wrap_pndng", {31'd0, bus.pndng}, 32'd0);
        check("pre_underflow", {31'd0, bus.underflow}, 32'd0);
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
        check("underflow", {31'd0, bus.underflow}, 32'd1);
        check("underflow_pndng", {31'd0, bus.pndng}, 32'd0);
        tick();
        check("underflow_sticky", {31'd0, bus.underflow}, 32'd1);

        // Asynchronous reset with both queues holding 5 entries
        for (int i = 0; i < 5; i++) tx_write(16'h0700 + 16'(i));
        for (int i = 0; i < 5; i++) rx_push(16'h0350 + 16'(i), 1'b0);
        check("pre_rst_rx_valid", {31'd0, bus.rx_valid}, 32'd1);
        bus.push     = 1'b1;
        bus.D_push   = 16'h03AB;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 16'h0ABC;
        #2;
        reset = 1'b1;
        #1;
        check("arst_pndng",     {31'd0, bus.pndng},       32'd0);
        check("arst_rx_valid",  {31'd0, bus.rx_valid},    32'd0);
        check("arst_drop",      {16'd0, bus.rx_drop_cnt}, 32'd0);
        check("arst_miss",      {16'd0, bus.rx_miss_cnt}, 32'd0);
        check("arst_underflow", {31'd0, bus.underflow},   32'd0);
        check("arst_tx_ready",  {31'd0, bus.tx_ready},    32'd1);
        tick();
        bus.push     = 1'b0;
        bus.tx_valid = 1'b0;
        #3;
        reset = 1'b0;
        tx_q.delete();
        rx_q.delete();
        tick();
        check("post_rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("post_rst_pndng",    {31'd0, bus.pndng},    32'd0);
        tx_write(16'h0A5A);
        check("post_rst_wr_pndng", {31'd0, bus.pndng}, 32'd1);
        check("post_rst_wr_D_pop", {16'd0, bus.D_pop}, 32'h0A5A);
        tx_pop();
        check("post_rst_empty", {31'd0, bus.pndng}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_endpoint_fifo.md
# bus_endpoint_fifo

Device-side endpoint of the shared data bus: the terminal the bus generator/arbiter pops packets from and pushes packets into. It holds a transmit queue that the device fills and the bus drains through `pndng`/`pop`/`D_pop`. It also holds a receive queue that the bus fills through `push`/`D_push` and the device drains. Incoming packets are address-filtered against the endpoint ID and the broadcast ID. One instance sits on each bus port, from 0 to `drvrs-1`.

## Interface
- `bits`, 1: bus width-config parameter carried for compatibility with the bus; no functional effect.
- `pckg_sz`, 16: packet width in bits; `[pckg_sz-1:pckg_sz-8]` is the destination ID, the rest is payload. Must be 9 or more.
- `depth`, 8: entries per queue, power of two, 2 or more.
- `id`, 0: this endpoint's 8-bit bus ID.
- `broadcast`, 8'hFF: destination ID accepted by every endpoint.

Ports:
- `clk`  in  1  bus clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `pndng`  out  1  transmit queue not empty.
- `pop`  in  1  bus consumes `D_pop` this cycle.
- `D_pop`  out  pckg_sz  transmit queue head; 0 when `pndng`=0.
- `push`  in  1  bus delivers `D_push` this cycle.
- `D_push`  in  pckg_sz  packet from bus.
- `tx_valid`  in  1  device write request.
- `tx_data`  in  pckg_sz  device packet; destination ID already in the top byte.
- `tx_ready`  out  1  transmit queue not full.
- `rx_valid`  out  1  receive queue not empty.
- `rx_data`  out  pckg_sz  receive queue head; 0 when `rx_valid`=0.
- `rx_ready`  in  1  device consumes `rx_data`.
- `rx_drop_cnt`  out  16  accepted-address packets lost because the receive queue was full; saturates at 16'hFFFF.
- `rx_miss_cnt`  out  16  packets ignored for address mismatch; saturates.
- `underflow`  out  1  sticky; set when `pop`=1 while `pndng`=0.

## Operation
- Both queues are circular buffers with read/write pointers of width log2(`depth`) and an occupancy count of width log2(`depth`)+1. Pointers wrap modulo `depth`.

Transmit queue:
- Write when `tx_valid & tx_ready`.
- Read when `pop & pndng`.
- Simultaneous write and read: count unchanged, both pointers advance.
- `tx_ready` = (count != `depth`), taken combinationally from the count register.
- When full, a write is refused even if `pop` arrives in the same cycle.

Receive path:
- Each `push` cycle, compare `D_push[pckg_sz-1:pckg_sz-8]` with `id` and `broadcast`.
- Match and not full: enqueue.
- Match and full: discard, `rx_drop_cnt`++.
- No match: discard, `rx_miss_cnt`++.
- Fullness is judged on the registered count. A device read in the same cycle does not make room.
- A device read occurs when `rx_valid & rx_ready`. A simultaneous enqueue and read leaves the count unchanged.

Error and no-op cases:
- `pop` with `pndng`=0 sets `underflow`, with no other effect. `underflow` clears only on reset.
- `rx_ready` with `rx_valid`=0: no effect.

Bus side:
- The bus has no backpressure toward the endpoint, so the endpoint never stalls `push`.

## Timing
Reset values:
- Asserting `reset` at any time, including mid-transfer, immediately forces both queues empty, counters 0 and `underflow` 0.
- Outputs during reset: `pndng`=0, `D_pop`=0, `tx_ready`=1, `rx_valid`=0, `rx_data`=0.
- A `push` or `tx_valid` coincident with reset is lost.

Latency:
- Device write at edge N: `pndng`=1 and `D_pop`=`tx_data` from edge N.
- Bus `pop` at edge N: the next entry appears on `D_pop` after edge N, or `pndng` falls if that was the last entry.
- Bus `push` accepted at edge N: `rx_valid`=1 and `rx_data`=`D_push` after edge N.

Data and flag outputs:
- `D_pop` and `rx_data` are combinational reads of the head entry, gated by the not-empty flag.
- All flags derive from registered counts, with no combinational path from `pop`, `push` or `rx_ready` to any output.

## Test plan
- Reset, then 3 device writes 16'h0211, 16'h0222, 16'h0233, then 3 bus pops one per cycle -> `D_pop` shows 0211, 0222, 0233 in order; `pndng` falls after the third pop; `D_pop`=0.
- With `id`=3, bus pushes 16'h03AA, 16'hFF55, 16'h0477 -> `rx_data` sequence 03AA, FF55; `rx_miss_cnt`=1; `rx_drop_cnt`=0.
- Fill the receive queue with 8 matching pushes (`rx_ready`=0), push 2 more -> `rx_drop_cnt`=2; reading yields the first 8 packets intact.
- Fill the transmit queue to 8 entries -> `tx_ready`=0; assert `tx_valid` and `pop` in the same cycle -> the write is refused, count goes to 7, `tx_ready`=1 next cycle.
- Write-pointer wrap: 20 interleaved writes and pops with 1-3 entries occupied -> FIFO order preserved across pointer wrap; `pop` on empty -> `underflow`=1.
- Assert `reset` with 5 entries in each queue while `push`=1 -> immediately `pndng`=0, `rx_valid`=0, both counters 0; after release, the first write behaves as from empty.
